// File: rtl/sram_d_arbiter.sv
// Two-manager round-robin OBI arbiter onto the SRAM data port; routes responses back via an owner-ID FIFO.
// Zero added latency on request and response; requests stall (s_req_o low) while the owner FIFO is full and nothing pops.
module sram_d_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m1_req_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        proto_err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] r_owner;
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic                       r_last;
    logic                       r_proto_err;

    logic w_any;
    logic w_sel;
    logic w_can_issue;
    logic w_hs;
    logic w_pop;
    logic w_head;
    logic w_stray;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign w_any = m0_req_i | m1_req_i;
    // Under contention the manager not granted last wins; otherwise whoever asks.
    assign w_sel = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;

    // A response arriving this cycle frees its FIFO slot in time for a new push.
    assign w_can_issue = (r_count < MAX_CNT) | s_rvalid_i;
    assign s_req_o     = w_any & w_can_issue & ~rst_i;
    assign w_hs        = s_req_o & s_gnt_i;
    assign m0_gnt_o    = w_hs & ~w_sel;
    assign m1_gnt_o    = w_hs & w_sel;

    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (w_any) begin
            if (w_sel) begin
                s_addr_o  = m1_addr_i;
                s_we_o    = m1_we_i;
                s_be_o    = m1_be_i;
                s_wdata_o = m1_wdata_i;
            end else begin
                s_addr_o  = m0_addr_i;
                s_we_o    = m0_we_i;
                s_be_o    = m0_be_i;
                s_wdata_o = m0_wdata_i;
            end
        end
    end

    assign w_pop   = s_rvalid_i & (r_count != '0) & ~rst_i;
    assign w_stray = s_rvalid_i & (r_count == '0);
    assign w_head  = r_owner[r_rd_ptr];

    assign m0_rvalid_o = w_pop & ~w_head;
    assign m1_rvalid_o = w_pop & w_head;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign proto_err_o = r_proto_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last      <= 1'b1;
            r_proto_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_owner[r_wr_ptr] <= w_sel;
                r_wr_ptr          <= f_next(r_wr_ptr);
                r_last            <= w_sel;
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            if (w_hs && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_stray) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Randomized scoreboard bench for sram_d_arbiter with an SRAM subordinate stub of configurable latency.
module tb_sram_d_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic        m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m0_be_i = '0, m1_be_i = '0;
    logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o;
    logic        s_gnt_i = 1'b1;
    logic [31:0] s_addr_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic        s_rvalid_i = 1'b0;
    logic [31:0] s_rdata_i = '0;
    logic        proto_err_o;

    sram_d_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
        .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
        .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
        .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
        .m0_be_i(m0_be_i), .m1_be_i(m1_be_i),
        .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i),
        .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } txn_t;
    typedef struct { logic owner; logic chk; logic [31:0] data; } rsp_t;
    typedef struct { int due; logic [31:0] data; } pend_t;

    txn_t  mq0[$], mq1[$];
    rsp_t  exp_q[$];
    pend_t pipe[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] stub_mem [logic [31:0]];

    int   checks = 0, fails = 0;
    int   cyc = 0;
    int   lat = 1;
    logic gnt_always = 1'b1;
    logic stray_req = 1'b0;
    logic g0_seen = 1'b0, g1_seen = 1'b0;
    logic m_last = 1'b1, m_err = 1'b0;
    logic [31:0] last_rd [2];
    logic gnt_log[$], rv_log[$];
    int   gnt_cyc[$], rv_cyc[$];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = w[8*i +: 8];
        return o;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.addr  = 32'h8000_0000 | (32'($urandom_range(15)) << 2);
        t.we    = 1'($urandom_range(1));
        t.be    = 4'($urandom_range(15));
        if (t.be == 4'h0) t.be = 4'hF;
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Manager drivers and subordinate response side, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (g0_seen && mq0.size() > 0) void'(mq0.pop_front());
            if (g1_seen && mq1.size() > 0) void'(mq1.pop_front());
            m0_req_i = mq0.size() > 0;
            m1_req_i = mq1.size() > 0;
            if (m0_req_i) begin
                m0_addr_i = mq0[0].addr; m0_we_i = mq0[0].we; m0_be_i = mq0[0].be; m0_wdata_i = mq0[0].wdata;
            end else begin
                m0_addr_i = $urandom; m0_we_i = 1'($urandom); m0_be_i = 4'($urandom); m0_wdata_i = $urandom;
            end
            if (m1_req_i) begin
                m1_addr_i = mq1[0].addr; m1_we_i = mq1[0].we; m1_be_i = mq1[0].be; m1_wdata_i = mq1[0].wdata;
            end else begin
                m1_addr_i = $urandom; m1_we_i = 1'($urandom); m1_be_i = 4'($urandom); m1_wdata_i = $urandom;
            end
            s_gnt_i    = gnt_always ? 1'b1 : ($urandom_range(3) != 0);
            s_rvalid_i = 1'b0;
            s_rdata_i  = $urandom;
            if (rst_i) begin
                pipe.delete();
            end else if (pipe.size() > 0 && pipe[0].due == cyc) begin
                s_rvalid_i = 1'b1;
                s_rdata_i  = pipe.pop_front().data;
            end else if (stray_req) begin
                s_rvalid_i = 1'b1;
                stray_req  = 1'b0;
            end
        end
    end

    // Reference model, scoreboard and response monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        logic sel, any, can, e_hs, e_pop, who;
        logic [31:0] a, old, act;
        rsp_t r;
        txn_t h;
        g0_seen = m0_gnt_o;
        g1_seen = m1_gnt_o;
        if (m0_gnt_o || m1_gnt_o) begin gnt_log.push_back(m1_gnt_o); gnt_cyc.push_back(cyc); end
        if (m0_rvalid_o || m1_rvalid_o) begin rv_log.push_back(m1_rvalid_o); rv_cyc.push_back(cyc); end

        if (rst_i) begin
            chk("rst_s_req", s_req_o, 0);
            chk("rst_gnt", {m1_gnt_o, m0_gnt_o}, 0);
            chk("rst_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
            exp_q.delete();
            m_last = 1'b1;
            m_err  = 1'b0;
        end else begin
            chk("proto_err", proto_err_o, m_err);
            any  = m0_req_i || m1_req_i;
            sel  = (m0_req_i && m1_req_i) ? !m_last : m1_req_i;
            can  = (exp_q.size() < MAXO) || s_rvalid_i;
            e_hs = any && can && s_gnt_i;
            chk("s_req", s_req_o, any && can);
            chk("m0_gnt", m0_gnt_o, e_hs && !sel);
            chk("m1_gnt", m1_gnt_o, e_hs && sel);
            if (!any) h = '{addr: 0, we: 0, be: 0, wdata: 0};
            else if (sel) h = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
            else h = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
            chk("s_addr", s_addr_o, h.addr);
            chk("s_we", s_we_o, h.we);
            chk("s_be", s_be_o, h.be);
            chk("s_wdata", s_wdata_o, h.wdata);
            chk("m0_rdata_pass", m0_rdata_o, s_rdata_i);
            chk("m1_rdata_pass", m1_rdata_o, s_rdata_i);

            e_pop = s_rvalid_i && exp_q.size() > 0;
            chk("rvalid_present", m0_rvalid_o || m1_rvalid_o, e_pop);
            chk("rvalid_onehot", m0_rvalid_o && m1_rvalid_o, 0);
            if ((m0_rvalid_o || m1_rvalid_o) && exp_q.size() > 0) begin
                r   = exp_q.pop_front();
                who = m1_rvalid_o;
                chk("rsp_owner", who, r.owner);
                act = who ? m1_rdata_o : m0_rdata_o;
                if (r.chk) chk("rsp_data", act, r.data);
                last_rd[who] = act;
            end
            if (s_rvalid_i && !e_pop) m_err = 1'b1;

            if (e_hs) begin
                a   = h.addr;
                old = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                if (h.we) ref_mem[a] = merge(old, h.wdata, h.be);
                exp_q.push_back('{owner: sel, chk: !h.we, data: old});
                m_last = sel;
            end
        end

        if (s_req_o && s_gnt_i) begin
            a   = s_addr_o;
            old = stub_mem.exists(a) ? stub_mem[a] : dflt(a);
            if (s_we_o) stub_mem[a] = merge(old, s_wdata_o, s_be_o);
            pipe.push_back('{due: cyc + lat, data: s_we_o ? 32'h0 : old});
        end
    end

    task automatic clear_logs();
        gnt_log.delete(); gnt_cyc.delete(); rv_log.delete(); rv_cyc.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mq0.size() > 0 || mq1.size() > 0 || exp_q.size() > 0 || pipe.size() > 0) && n < 300) begin
            @(posedge clk); n++;
        end
        chk("idle_timeout", n >= 300, 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        txn_t t;
        int rel_cyc;
        logic exp_alt[6];
        exp_alt = '{0, 1, 0, 1, 0, 1};

        // Reset with both managers already requesting.
        t = '{addr: 32'h8000_0010, we: 0, be: 4'hF, wdata: 0};
        mq0.push_back(t);
        t.addr = 32'h8000_0014;
        mq1.push_back(t);
        repeat (2) @(posedge clk);
        #2;
        rst_i   = 1'b0;
        rel_cyc = cyc;
        wait_idle();
        chk("reset_gnt_count", gnt_log.size(), 2);
        if (gnt_log.size() > 0) begin
            chk("first_gnt_is_m0", gnt_log[0], 0);
            chk("first_gnt_cycle", gnt_cyc[0], rel_cyc);
        end

        // Single m1 read while m0 idles.
        clear_logs();
        mq1.push_back('{addr: 32'h8000_0004, we: 0, be: 4'hF, wdata: 0});
        wait_idle();
        chk("single_gnt_count", gnt_log.size(), 1);
        chk("single_rv_count", rv_log.size(), 1);
        if (gnt_log.size() == 1 && rv_log.size() == 1) begin
            chk("single_gnt_m1", gnt_log[0], 1);
            chk("single_rv_m1", rv_log[0], 1);
            chk("single_rv_latency", rv_cyc[0], gnt_cyc[0] + 1);
            chk("single_rdata", last_rd[1], dflt(32'h8000_0004));
        end

        // Contention: grants must alternate starting with m0.
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            mq0.push_back('{addr: 32'h8000_0020 + 32'(8*i), we: 0, be: 4'hF, wdata: 0});
            mq1.push_back('{addr: 32'h8000_0024 + 32'(8*i), we: 0, be: 4'hF, wdata: 0});
        end
        wait_idle();
        chk("cont_gnt_count", gnt_log.size(), 6);
        chk("cont_rv_count", rv_log.size(), 6);
        if (gnt_log.size() == 6 && rv_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("cont_gnt_order", gnt_log[i], exp_alt[i]);
                chk("cont_rv_owner", rv_log[i], exp_alt[i]);
                chk("cont_rv_latency", rv_cyc[i], gnt_cyc[i] + 1);
            end
        end

        // Full owner FIFO with a 3-cycle subordinate.
        clear_logs();
        lat = 3;
        for (int i = 0; i < 4; i++) mq0.push_back('{addr: 32'h8000_0040 + 32'(4*i), we: 0, be: 4'hF, wdata: 0});
        wait_idle();
        lat = 1;
        chk("full_gnt_count", gnt_log.size(), 4);
        chk("full_rv_count", rv_log.size(), 4);
        if (gnt_log.size() >= 3 && rv_log.size() >= 1) begin
            chk("full_second_gnt", gnt_cyc[1], gnt_cyc[0] + 1);
            chk("full_third_gnt_on_rvalid", gnt_cyc[2], rv_cyc[0]);
            chk("full_third_gnt_cycle", gnt_cyc[2], gnt_cyc[0] + 3);
        end

        // Partial write then read back.
        mq0.push_back('{addr: 32'h8000_0100, we: 1, be: 4'b0011, wdata: 32'hDEAD_BEEF});
        mq0.push_back('{addr: 32'h8000_0100, we: 0, be: 4'hF, wdata: 0});
        wait_idle();
        chk("write_merge", last_rd[0], {dflt(32'h8000_0100) >> 16, 16'hBEEF} & 32'hFFFF_FFFF);

        // Stray response sets a sticky error that only reset clears.
        stray_req = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("stray_sticky", proto_err_o, 1);
        rst_i = 1'b1;
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        @(posedge clk);
        #2;
        chk("stray_cleared", proto_err_o, 0);

        // Randomized traffic with random subordinate grant and varying latency.
        gnt_always = 1'b0;
        for (int seg = 0; seg < 4; seg++) begin
            lat = 1 + (seg % 3);
            for (int c = 0; c < 150; c++) begin
                @(posedge clk);
                #2;
                if (mq0.size() < 3 && $urandom_range(1)) mq0.push_back(rand_txn());
                if (mq1.size() < 3 && $urandom_range(1)) mq1.push_back(rand_txn());
            end
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sram_d_arbiter.md
# sram_d_arbiter

Two-manager OBI arbiter that produces the single muxed data-side OBI stream consumed by the SRAM wrapper's `sram_d_*` port. Manager 0 is the core data port; manager 1 is the host/loader bridge. Requests are arbitrated round-robin, and an owner-ID FIFO routes each in-order response back to the manager that issued it. The block adds zero cycles to either the request path or the response path.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: depth of the owner-ID FIFO, i.e. the maximum number of granted-but-unanswered requests (≥1).

Ports:
- `clk_i`  in  1  clock; the only clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `m0_req_i`, `m1_req_i`  in  1  manager request.
- `m0_gnt_o`, `m1_gnt_o`  out  1  manager grant.
- `m0_addr_i`, `m1_addr_i`  in  32  byte address.
- `m0_we_i`, `m1_we_i`  in  1  write enable.
- `m0_be_i`, `m1_be_i`  in  4  byte enables.
- `m0_wdata_i`, `m1_wdata_i`  in  32  write data.
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  response valid.
- `m0_rdata_o`, `m1_rdata_o`  out  32  response data.
- `s_req_o`  out  1  request to the SRAM wrapper `sram_d` port.
- `s_gnt_i`  in  1  grant from the SRAM wrapper.
- `s_addr_o`  out  32  muxed address.
- `s_we_o`  out  1  muxed write enable.
- `s_be_o`  out  4  muxed byte enables.
- `s_wdata_o`  out  32  muxed write data.
- `s_rvalid_i`  in  1  response valid from the SRAM wrapper.
- `s_rdata_i`  in  32  response data from the SRAM wrapper.
- `proto_err_o`  out  1  sticky flag: `s_rvalid_i` arrived with no outstanding owner.

## Operation
- **State:**
  - `last_q`: ID of the manager granted last.
  - Owner FIFO: 1-bit entries, `MAX_OUTSTANDING` deep, with pointers and a count.
  - `proto_err_q`.
- **can_issue:** `count < MAX_OUTSTANDING`, or `s_rvalid_i` is asserted this cycle (a pop frees a slot in the same cycle).
- **Selection:**
  - Only m0 requests: sel=0. Only m1 requests: sel=1.
  - Both request: sel = !`last_q`.
  - `sel` is combinational.
- **Request path:**
  - `s_req_o` = (m0_req | m1_req) & can_issue & !rst_i.
  - `s_addr_o`, `s_we_o`, `s_be_o`, `s_wdata_o` are taken from the selected manager.
  - When no manager requests, these outputs are driven to 0.
- **Grants:**
  - `mX_gnt_o` = `s_req_o` & `s_gnt_i` & (sel==X).
  - At most one manager grant is high per cycle.
  - The unselected manager holds its request and is served later.
- **Handshake** (`s_req_o` & `s_gnt_i`):
  - Push `sel` into the FIFO.
  - Set `last_q` <= `sel`.
- **Response:**
  - On `s_rvalid_i` with count>0: pop the head; assert `m[head]_rvalid_o` in the same cycle; pass `s_rdata_i` through to that manager.
  - Both `mX_rdata_o` are driven from `s_rdata_i`; only the rvalid is steered.
- **Simultaneous push and pop:** count is unchanged; the FIFO head and tail both advance.
- **Stray response:** `s_rvalid_i` with count==0 and no pop:
  - Both manager rvalids stay 0.
  - `proto_err_q` <= 1.
  - The flag clears only on reset.
- **Full FIFO:**
  - With count==MAX_OUTSTANDING and no pop, `s_req_o`=0 and both grants are 0.
  - No request is dropped; managers hold their requests.
- **Reset:**
  - `rst_i` high clears the FIFO (count=0, pointers=0).
  - `last_q` <= 1, so m0 wins the first contention after reset.
  - `proto_err_q` <= 0.
  - While `rst_i` is high, `s_req_o`, both grants and both rvalids are forced to 0.
  - Responses still in flight at reset are dropped; with the SRAM wrapper this cannot occur, because `s_req_o` is 0 during the last reset cycle.

## Timing
- **Reset values of outputs:**
  - 0: `s_req_o`, `mX_gnt_o`, `mX_rvalid_o`, `proto_err_o`.
  - `s_addr_o`, `s_we_o`, `s_be_o`, `s_wdata_o`: 0 when no request, otherwise the muxed manager fields (combinational).
  - `mX_rdata_o` = `s_rdata_i`.
- **Request path:** combinational from `mX_req_i` to `s_req_o`, and from `s_gnt_i` to `mX_gnt_o`. No added latency.
- **Response path:** combinational from `s_rvalid_i` to `mX_rvalid_o`. No added latency.
- **End-to-end with the SRAM wrapper:** a grant in cycle N (the wrapper grants in the cycle of the request) gives `mX_rvalid_o` in cycle N+1.
- **Throughput:**
  - One request per cycle is sustained when `MAX_OUTSTANDING` ≥ 1 and the wrapper responds in the next cycle, because pop and push share a cycle.
  - Under contention, grants alternate m0, m1, m0, …

## Test plan
- **Reset:** hold `rst_i` 2 cycles with both requests high. Required: `s_req_o`=0, grants 0, rvalids 0. In the first cycle after reset, `m0_gnt_o`=1.
- **Single manager read:** m1 reads 0x8000_0004 while m0 is idle. Required: `m1_gnt_o`=1 in cycle N; `m1_rvalid_o`=1 in N+1 carrying the SRAM word; `m0_rvalid_o` stays 0.
- **Contention:** both managers request continuously for 6 cycles. Required: grant order m0,m1,m0,m1,m0,m1, and each rvalid reaches the correct manager one cycle after its grant.
- **Full FIFO** (`MAX_OUTSTANDING`=2, subordinate stub with 3-cycle response latency): back-to-back m0 requests. Required: a third grant occurs only in the cycle the first `s_rvalid_i` arrives; no request is lost.
- **Write merge:** m0 writes 0xDEADBEEF with `be`=4'b0011 to 0x8000_0100, then reads it back. Required: read data [15:0]=0xBEEF and the upper half unchanged.
- **Stray response:** inject `s_rvalid_i` with an empty FIFO. Required: `proto_err_o`=1 from the next cycle and stays 1; no manager rvalid; cleared by reset.
